// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub.
// Master drives the request, slave returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, LSB first.
// Subtraction is a + ~b + ~borrow through the same carry register.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic            clock,
  input  logic            resetn,
  serial_addsub_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK:0]   slice;
  logic             c_msb;

  // Chunk adder; c_msb is the carry into the chunk's top bit
  always_comb begin
    slice = {1'b0, a_q[CHUNK-1:0]}
          + {1'b0, b_q[CHUNK-1:0]}
          + (CHUNK + 1)'(carry_q);
    c_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1]
          ^ slice[CHUNK-1];
  end

  // Next-state: capture on start, shift one chunk per RUN cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_q >> CHUNK;
        res_d[WIDTH-1 -: CHUNK] = slice[CHUNK-1:0];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = slice[CHUNK];
          ovf_d   = c_msb ^ slice[CHUNK];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
